seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode/cathode 7-segment display built from a single shared 4-bit-to-7-segment decoder. Cycles the shared decoder input through NUM_DIGITS nibbles and drives a one-hot digit enable, with a blanking guard between digits. Provides frame-synchronous (tear-free) display updates via a req/ack load handshake and optional leading-zero suppression. Sits between the system's value producer and the segment decoder; decoder and pad inversion are outside this block.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=2)
REFRESH_DIV, 1000, clk cycles each digit is shown (>=1)
BLANK_CYCLES, 2, clk cycles all digits off before each digit (>=0; 0 = no blank phase)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
enable  input  1  scan enable; 0 = display dark
load_req  input  1  request to update the displayed value
value_in  input  4*NUM_DIGITS  nibble k = digit k (digit 0 = rightmost/LSD)
dp_in  input  NUM_DIGITS  decimal point per digit
lz_en  input  1  leading-zero suppression enable
load_ack  output  1  one-cycle pulse: pending value became active
digit_bcd  output  4  nibble to shared decoder
dp  output  1  decimal point for current digit
digit_en  output  NUM_DIGITS  one-hot digit enable, active-high

Behaviour:
- Reset (async, immediate): state=IDLE, digit index=0, counters=0, active value/dp=0, pending value/dp=0, pending flag=0; digit_bcd=0, dp=0, digit_en=0, load_ack=0.
- All outputs registered; each output changes one cycle after its causing event.
- States: IDLE, BLANK, SHOW.
- IDLE: digit_en=0, dp=0. When enable=1: next state BLANK (SHOW if BLANK_CYCLES=0) with index=0.
- BLANK: lasts exactly BLANK_CYCLES cycles; digit_en=0, dp=0; digit_bcd already = active nibble[index], so the decoder settles before enable.
- SHOW: lasts exactly REFRESH_DIV cycles; digit_bcd=nibble[index], dp=active dp[index], digit_en=one-hot(index) unless suppressed. Then index increments; after NUM_DIGITS-1 it wraps to 0 (frame boundary) and goes to BLANK (or SHOW).
- Frame length = NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
- enable=0 in any state: next cycle IDLE, digit_en=0, index and counters cleared; re-enable restarts at digit 0.
- Load handshake: each cycle with load_req=1 captures value_in/dp_in into pending and sets the flag (last write wins). At a frame boundary (last SHOW cycle of the last digit), or any cycle in IDLE, a set flag copies pending->active, clears the flag and pulses load_ack for exactly one cycle. If load_req=1 in the same cycle as the transfer, that cycle's value_in/dp_in goes straight to active and the flag stays clear (single ack). Active never changes mid-frame.
- Leading-zero suppression (lz_en=1): digit k is suppressed if every nibble from NUM_DIGITS-1 down to k is 0 and k!=0. Suppressed digits keep their timing slot but digit_en=0 and dp=0 for the slot. Digit 0 is never suppressed. Nibbles >9 count as nonzero.
- Nibbles are passed through unchanged (hex 0-F allowed).
- Counter widths are clog2 of the respective maximum; no overflow is possible.

Test Plan (bench: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, 20-cycle frame):
- Reset mid-SHOW with digit_en=0100 -> digit_en=0000, digit_bcd=0, load_ack=0 immediately, before the next clk edge.
- enable=1, active=16'h1234 -> repeating 1 blank + 4 show cycles: digit_bcd 4,3,2,1; digit_en 0001,0010,0100,1000; 20-cycle period.
- load_req pulse with 16'hABCD at cycle 5 of a frame -> display still 1234 until the frame ends, then one load_ack pulse, next frame shows D,C,B,A. Two requests in one frame -> only the last value is shown, single ack.
- lz_en=1, value 16'h0050 -> digits 3 and 2 dark in their slots, digits 1 (5) and 0 (0) lit. Value 16'h0000 -> only digit 0 lit showing 0. lz_en=0 -> all four lit.
- dp_in=4'b0010 with value 16'h1234 -> dp=1 only during the digit 1 SHOW cycles; 0 during BLANK and the other digits.
- enable dropped mid-frame then raised -> digit_en=0 while low; restart at digit 0 with a BLANK cycle. load_req while in IDLE -> load_ack next cycle.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- time-multiplexed scan controller for a multi-digit
// 7-segment display that shares a single 4-bit-to-7-segment decoder.
//
// The controller steps the shared decoder input through every digit nibble.
// Before each digit is lit, it holds a short blanking gap with all digit
// enables off. Display updates are tear-free: a new value is only promoted
// to the visible ("active") copy at a frame boundary or while idle.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous reset, active-high
//   enable_i     scan enable; 0 = display dark, scan restarts at digit 0
//   load_req_i   request to update the displayed value
//   value_in_i   nibble k = digit k (digit 0 = rightmost)
//   dp_in_i      decimal point per digit
//   lz_en_i      leading-zero suppression enable
//   load_ack_o   one-cycle pulse: pending value became active
//   digit_bcd_o  nibble to the shared decoder
//   dp_o         decimal point for the current digit
//   digit_en_o   one-hot digit enable, active-high
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    load_req_i,
  input  logic [4*NUM_DIGITS-1:0] value_in_i,
  input  logic [NUM_DIGITS-1:0]   dp_in_i,
  input  logic                    lz_en_i,
  output logic                    load_ack_o,
  output logic [3:0]              digit_bcd_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   digit_en_o
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // With no blanking gap configured, each digit slot starts directly in SHOW.
  localparam state_t FIRST_STATE = (BLANK_CYCLES > 0) ? BLANK : SHOW;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        digitIdx_q, digitIdx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] activeVal_q, activeVal_d;
  logic [NUM_DIGITS-1:0]   activeDp_q, activeDp_d;
  logic [4*NUM_DIGITS-1:0] pendVal_q, pendVal_d;
  logic [NUM_DIGITS-1:0]   pendDp_q, pendDp_d;
  logic                    pendFlag_q, pendFlag_d;
  logic                    loadAck_q, loadAck_d;
  logic [3:0]              digitBcd_q, digitBcd_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   digitEn_q, digitEn_d;
  logic                    xferPoint;

  // A digit is a leading zero when it and every more significant nibble are
  // zero. Digit 0 is never marked, so a value of zero still shows a single 0.
  function automatic logic [NUM_DIGITS-1:0] leadZeroMask(input logic [4*NUM_DIGITS-1:0] v);
    logic [NUM_DIGITS-1:0] m;
    logic                  allZero;
    m       = '0;
    allZero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      allZero = allZero & (v[4*k +: 4] == 4'h0);
      m[k]    = allZero;
    end
    return m;
  endfunction

  // Scan sequencer. Each digit gets a BLANK gap followed by a SHOW slot.
  // Dropping enable returns to IDLE from any state and clears the position.
  always_comb begin
    state_d    = state_q;
    digitIdx_d = digitIdx_q;
    cnt_d      = cnt_q;
    if (!enable_i) begin
      state_d    = IDLE;
      digitIdx_d = '0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = FIRST_STATE;
          digitIdx_d = '0;
          cnt_d      = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d    = FIRST_STATE;
            cnt_d      = '0;
            digitIdx_d = (digitIdx_q == IDX_LAST) ? '0 : digitIdx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d    = IDLE;
          digitIdx_d = '0;
          cnt_d      = '0;
        end
      endcase
    end
  end

  // Load handshake. Requests land in a pending buffer. The pending value is
  // promoted only on the last SHOW cycle of the last digit, or while idle, so
  // a frame never mixes old and new digits. A request arriving on the
  // promotion cycle itself bypasses the buffer, so it still produces only one
  // acknowledge.
  always_comb begin
    xferPoint   = (state_q == IDLE) ||
                  ((state_q == SHOW) && (cnt_q == SHOW_LAST) && (digitIdx_q == IDX_LAST));
    activeVal_d = activeVal_q;
    activeDp_d  = activeDp_q;
    pendVal_d   = pendVal_q;
    pendDp_d    = pendDp_q;
    pendFlag_d  = pendFlag_q;
    loadAck_d   = 1'b0;
    if (xferPoint && (pendFlag_q || load_req_i)) begin
      activeVal_d = load_req_i ? value_in_i : pendVal_q;
      activeDp_d  = load_req_i ? dp_in_i : pendDp_q;
      pendFlag_d  = 1'b0;
      loadAck_d   = 1'b1;
    end else if (load_req_i) begin
      pendVal_d  = value_in_i;
      pendDp_d   = dp_in_i;
      pendFlag_d = 1'b1;
    end
  end

  // Output values are derived from the next state and registered, so they
  // line up with the state registers. The nibble is presented during BLANK
  // too, which gives the external decoder time to settle before the digit
  // is enabled. A suppressed digit keeps its time slot but stays dark.
  always_comb begin
    logic [NUM_DIGITS-1:0] lzMask;
    logic                  lit;
    lzMask     = lz_en_i ? leadZeroMask(activeVal_d) : '0;
    lit        = (state_d == SHOW) && !lzMask[digitIdx_d];
    digitBcd_d = (state_d == IDLE) ? 4'h0 : activeVal_d[{digitIdx_d, 2'b00} +: 4];
    digitEn_d  = lit ? (NUM_DIGITS'(1) << digitIdx_d) : '0;
    dp_d       = lit && activeDp_d[digitIdx_d];
  end

  // All state and output registers, cleared immediately by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      digitIdx_q  <= '0;
      cnt_q       <= '0;
      activeVal_q <= '0;
      activeDp_q  <= '0;
      pendVal_q   <= '0;
      pendDp_q    <= '0;
      pendFlag_q  <= 1'b0;
      loadAck_q   <= 1'b0;
      digitBcd_q  <= 4'h0;
      dp_q        <= 1'b0;
      digitEn_q   <= '0;
    end else begin
      state_q     <= state_d;
      digitIdx_q  <= digitIdx_d;
      cnt_q       <= cnt_d;
      activeVal_q <= activeVal_d;
      activeDp_q  <= activeDp_d;
      pendVal_q   <= pendVal_d;
      pendDp_q    <= pendDp_d;
      pendFlag_q  <= pendFlag_d;
      loadAck_q   <= loadAck_d;
      digitBcd_q  <= digitBcd_d;
      dp_q        <= dp_d;
      digitEn_q   <= digitEn_d;
    end
  end

  assign load_ack_o  = loadAck_q;
  assign digit_bcd_o = digitBcd_q;
  assign dp_o        = dp_q;
  assign digit_en_o  = digitEn_q;

endmodule
